// File: rtl/tx_arb_pkg.sv
// Shared types for the UART output FIFO arbiter: FSM states, byte type and
// the id-width helper that keeps single-requester builds at one bit.
package tx_arb_pkg;

    typedef enum logic {IDLE, GRANT} arb_state_t;

    typedef logic [7:0] data_byte_t;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin priority encoder: returns the first set request
// at or after rr_ptr, wrapping modulo NUM_REQ.
module rr_pick
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    rr_ptr,
    output logic               found,
    output logic [ID_W-1:0]    index
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [2*NUM_REQ-1:0] shifted;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      offset;
    logic [ID_W:0]        sum;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the lowest set bit wins.
    assign doubled = {req, req};
    assign shifted = doubled >> rr_ptr;
    assign rotated = shifted[NUM_REQ-1:0];

    always_comb begin
        found  = 1'b0;
        offset = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                found  = 1'b1;
                offset = ID_W'(i);
            end
        end
    end

    always_comb begin
        sum = {1'b0, rr_ptr} + {1'b0, offset};
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        index = sum[ID_W-1:0];
    end

endmodule

// File: rtl/tx_fifo_arbiter.sv
// Round-robin arbiter sharing the UART output FIFO between byte-stream
// requesters; a grant is locked until the packet's last byte or MAX_BURST bytes.
module tx_fifo_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16,
    localparam int ID_W = id_width(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             fifo_din,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    output logic [ID_W-1:0]        grant_id,
    output logic                   busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    arb_state_t       state_next;
    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  next_ptr;
    logic [ID_W-1:0]  pick_idx;
    logic             pick_found;
    logic [CNT_W-1:0] burst_cnt;
    logic             transfer;
    logic             release_grant;
    data_byte_t       req_bytes [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
        assign req_bytes[i] = req_data[8*i +: 8];
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .found  (pick_found),
        .index  (pick_idx)
    );

    assign busy = (state == GRANT);

    // Handshake and write strobe come straight from the registered grant, so a
    // write can never be issued while the FIFO reports full.
    always_comb begin
        state_next    = state;
        req_ready     = '0;
        fifo_wr_en    = 1'b0;
        fifo_din      = req_bytes[grant_id];
        transfer      = 1'b0;
        release_grant = 1'b0;
        next_ptr      = (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_next = GRANT;
                end
            end
            GRANT: begin
                req_ready[grant_id] = !fifo_full;
                transfer            = req_valid[grant_id] & !fifo_full;
                fifo_wr_en          = transfer;
                release_grant       = transfer &
                                      (req_last[grant_id] |
                                       (burst_cnt == CNT_W'(MAX_BURST - 1)));
                if (release_grant) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            grant_id  <= '0;
            burst_cnt <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && pick_found) begin
                grant_id  <= pick_idx;
                burst_cnt <= '0;
            end
            if (transfer && burst_cnt != CNT_W'(MAX_BURST)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
            // The requester just released drops to lowest priority.
            if (release_grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end

endmodule

// File: tb/tb_tx_fifo_arbiter.sv
// Directed bench for tx_fifo_arbiter (2 requesters, MAX_BURST=4) driven from
// per-cycle tables of hand-computed expected outputs.
module tb_tx_fifo_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  fifo_din;
    logic        fifo_wr_en;
    logic        fifo_full;
    logic [0:0]  grant_id;
    logic        busy;

    int checks;
    int errors;

    int tRst[$], tFull[$], tWr[$], tDin[$], tBusy[$], tRdy[$], tGid[$];
    int s0Data[$], s0Last[$], s1Data[$], s1Last[$];
    int s0Start, s1Start;

    tx_fifo_arbiter #(
        .NUM_REQ   (2),
        .MAX_BURST (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .fifo_din   (fifo_din),
        .fifo_wr_en (fifo_wr_en),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic r, input logic [1:0] v,
                                 input logic [15:0] d, input logic [1:0] l,
                                 input logic f);
        @(negedge clk);
        rst       = r;
        req_valid = v;
        req_data  = d;
        req_last  = l;
        fifo_full = f;
        #1;
    endtask

    function automatic int at(input int q[$], input int c);
        return (c < q.size()) ? q[c] : 0;
    endfunction

    task automatic runScenario(input string name, input int n);
        int idx0 = 0;
        int idx1 = 0;
        logic v0, v1;
        logic [7:0] d0, d1;
        logic l0, l1;
        for (int c = 0; c < n; c++) begin
            v0 = (c >= s0Start) && (idx0 < s0Data.size());
            v1 = (c >= s1Start) && (idx1 < s1Data.size());
            d0 = v0 ? 8'(s0Data[idx0]) : 8'h00;
            d1 = v1 ? 8'(s1Data[idx1]) : 8'h00;
            l0 = v0 ? (s0Last[idx0] != 0) : 1'b0;
            l1 = v1 ? (s1Last[idx1] != 0) : 1'b0;
            applyStimulus(at(tRst, c) != 0, {v1, v0}, {d1, d0}, {l1, l0},
                          at(tFull, c) != 0);
            checkOutput($sformatf("%s c%0d wr_en", name, c), 32'(fifo_wr_en), 32'(tWr[c]));
            if (tWr[c] != 0) begin
                checkOutput($sformatf("%s c%0d din", name, c), 32'(fifo_din), 32'(tDin[c]));
            end
            checkOutput($sformatf("%s c%0d busy", name, c), 32'(busy), 32'(tBusy[c]));
            checkOutput($sformatf("%s c%0d ready", name, c), 32'(req_ready), 32'(tRdy[c]));
            checkOutput($sformatf("%s c%0d grant_id", name, c), 32'(grant_id), 32'(tGid[c]));
            if (v0 && tRdy[c][0]) idx0++;
            if (v1 && tRdy[c][1]) idx1++;
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;

        // Reset held with both requesters valid: nothing may be granted.
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'b11, 16'h0000, 2'b00, 1'b0);
            checkOutput("rst wr_en", 32'(fifo_wr_en), 32'd0);
            checkOutput("rst ready", 32'(req_ready), 32'd0);
            checkOutput("rst busy", 32'(busy), 32'd0);
        end
        applyStimulus(1'b0, 2'b11, 16'h0000, 2'b00, 1'b0);
        checkOutput("post-rst idle busy", 32'(busy), 32'd0);
        checkOutput("post-rst idle ready", 32'(req_ready), 32'd0);

        // Basic three-byte packet from requester 0.
        applyStimulus(1'b0, 2'b01, 16'h0041, 2'b00, 1'b0);
        checkOutput("basic grant_id", 32'(grant_id), 32'd0);
        checkOutput("basic busy", 32'(busy), 32'd1);
        checkOutput("basic wr0", 32'(fifo_wr_en), 32'd1);
        checkOutput("basic din0", 32'(fifo_din), 32'h41);
        checkOutput("basic ready0", 32'(req_ready), 32'd1);
        applyStimulus(1'b0, 2'b01, 16'h0042, 2'b00, 1'b0);
        checkOutput("basic wr1", 32'(fifo_wr_en), 32'd1);
        checkOutput("basic din1", 32'(fifo_din), 32'h42);
        applyStimulus(1'b0, 2'b01, 16'h0043, 2'b01, 1'b0);
        checkOutput("basic wr2", 32'(fifo_wr_en), 32'd1);
        checkOutput("basic din2", 32'(fifo_din), 32'h43);
        applyStimulus(1'b0, 2'b00, 16'h0000, 2'b00, 1'b0);
        checkOutput("basic idle busy", 32'(busy), 32'd0);
        checkOutput("basic idle wr", 32'(fifo_wr_en), 32'd0);

        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b00, 1'b0);

        // Round robin: both always valid, 2-byte packets.
        s0Data = '{'hA0, 'hA1, 'hA2, 'hA3}; s0Last = '{0, 1, 0, 1}; s0Start = 0;
        s1Data = '{'hB0, 'hB1, 'hB2, 'hB3}; s1Last = '{0, 1, 0, 1}; s1Start = 0;
        tRst = {}; tFull = {};
        tWr   = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        tDin  = '{0, 'hA0, 'hA1, 0, 'hB0, 'hB1, 0, 'hA2, 'hA3, 0, 'hB2, 'hB3};
        tBusy = '{0, 1, 1, 0, 1, 1, 0, 1, 1, 0, 1, 1};
        tRdy  = '{0, 1, 1, 0, 2, 2, 0, 1, 1, 0, 2, 2};
        tGid  = '{0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1};
        runScenario("rr", 12);

        // Burst limit: requester 1 streams 10 bytes without last, requester 0
        // slips single-byte packets in between groups; grant then stays locked.
        s0Data = '{'h55, 'h56}; s0Last = '{1, 1}; s0Start = 0;
        s1Data = '{'h10, 'h11, 'h12, 'h13, 'h14, 'h15, 'h16, 'h17, 'h18, 'h19};
        s1Last = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0}; s1Start = 0;
        tWr   = '{0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
        tDin  = '{0, 'h55, 0, 'h10, 'h11, 'h12, 'h13, 0, 'h56, 0,
                  'h14, 'h15, 'h16, 'h17, 0, 'h18, 'h19, 0, 0};
        tBusy = '{0, 1, 0, 1, 1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 0, 1, 1, 1, 1};
        tRdy  = '{0, 1, 0, 2, 2, 2, 2, 0, 1, 0, 2, 2, 2, 2, 0, 2, 2, 2, 2};
        tGid  = '{1, 0, 0, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        runScenario("burst", 19);

        applyStimulus(1'b1, 2'b00, 16'h0000, 2'b00, 1'b0);

        // Backpressure: FIFO full for 5 cycles after the first byte.
        s0Data = '{'h61, 'h62, 'h63, 'h64}; s0Last = '{0, 0, 0, 1}; s0Start = 0;
        s1Data = {}; s1Last = {}; s1Start = 0;
        tFull = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        tWr   = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tDin  = '{0, 'h61, 0, 0, 0, 0, 0, 'h62, 'h63, 'h64, 0};
        tBusy = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
        tRdy  = '{0, 1, 0, 0, 0, 0, 0, 1, 1, 1, 0};
        tGid  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        runScenario("bp", 11);

        // Reset during byte 2 of requester 1's packet; requester 0 wins after.
        s0Data = '{'hD0}; s0Last = '{1}; s0Start = 3;
        s1Data = '{'hC0, 'hC1, 'hC2, 'hC3}; s1Last = '{0, 0, 0, 1}; s1Start = 0;
        tFull = {};
        tRst  = '{0, 0, 1, 0, 0};
        tWr   = '{0, 1, 1, 0, 1};
        tDin  = '{0, 'hC0, 'hC1, 0, 'hD0};
        tBusy = '{0, 1, 1, 0, 1};
        tRdy  = '{0, 2, 2, 0, 1};
        tGid  = '{0, 1, 1, 0, 0};
        runScenario("rstmid", 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_fifo_arbiter.md
Name: tx_fifo_arbiter

Overview:
- Shares the single UART output FIFO (the `fifo_buffer` instance in front of the transmitter) between NUM_REQ byte-stream requesters.
- Typical requesters: the loopback echo path and a status/message generator.
- Round-robin arbitration with packet lock: a grant is held until the requester marks the last byte, or until MAX_BURST bytes have been written.
- Replaces the direct wr_en/din drive into the output FIFO.

Parameters:
- NUM_REQ, 2, number of requesters (2..8)
- MAX_BURST, 16, maximum bytes written per grant before forced rotation (1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  requester i has a byte on req_data
- req_data  in  8*NUM_REQ  byte of requester i at bits [8*i+7:8*i]
- req_last  in  NUM_REQ  byte of requester i is the end of its packet
- req_ready  out  NUM_REQ  byte of requester i is accepted this cycle
- fifo_din  out  8  write data to output FIFO
- fifo_wr_en  out  1  write strobe to output FIFO
- fifo_full  in  1  output FIFO full
- grant_id  out  $clog2(NUM_REQ)  currently/last granted requester
- busy  out  1  a grant is active

Behaviour:
- Clocking and reset: one clock domain. Synchronous active-high reset. Reset takes priority over every other event.
- Reset values: state=IDLE, rr_ptr=0, grant_id=0, burst_cnt=0, busy=0.
- Reset combinational effect: req_ready=0 and fifo_wr_en=0 on every cycle where the registered state is IDLE, including the reset cycle.
- FSM states: IDLE, GRANT.
- IDLE:
  - If any req_valid is set, select the first set index searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ.
  - Register grant_id, go to GRANT, busy=1, burst_cnt=0.
  - No byte is accepted in IDLE, so grant latency is 1 cycle from valid to the first possible transfer.
  - If no req_valid is set, stay in IDLE.
- GRANT, with g=grant_id:
  - req_ready[g] = !fifo_full (combinational).
  - req_ready of every other requester = 0.
  - transfer = req_valid[g] & req_ready[g].
  - fifo_wr_en = transfer and fifo_din = req_data[g], both combinational from the registered grant.
  - This guarantees no write is issued while fifo_full=1.
- Per transfer: burst_cnt increments, saturating width $clog2(MAX_BURST+1).
- Grant release: on a transfer where req_last[g]=1 or burst_cnt==MAX_BURST-1:
  - go to IDLE next cycle;
  - set rr_ptr = (g+1) mod NUM_REQ;
  - set busy=0.
- Packet lock: if req_valid[g] drops mid-packet, the grant is held, with no timeout. Requesters must finish packets.
- Flow control: fifo_full during GRANT stalls the transfer (ready=0). The grant and burst_cnt are held.
- Simultaneous events:
  - A new request arriving during GRANT waits for release.
  - The requester just released is lowest priority in the next IDLE pick.
- Throughput: at most one byte per cycle. One dead IDLE cycle separates consecutive grants.
- NUM_REQ=1: rr_ptr is constant 0 and the block behaves as a pass-through with a 1-cycle grant setup.
- grant_id holds its last value in IDLE.

Decomposition:
- Package tx_arb_pkg:
  - state enum (IDLE, GRANT);
  - localparam function for the id width ($clog2 with minimum 1);
  - byte typedef (logic [7:0]).
- Sub-module rr_pick: purely combinational round-robin priority encoder.
  - Inputs: req vector, rr_ptr.
  - Outputs: found, index.
  - Instantiated once in tx_fifo_arbiter.

Test Plan:
- Reset behaviour: rst held 3 cycles with req_valid=2'b11 -> fifo_wr_en=0, req_ready=0, busy=0. One cycle after rst falls: grant_id=0, busy=1.
- Basic packet: req0 sends 0x41,0x42,0x43 with last on 0x43, fifo_full=0 -> three consecutive fifo_wr_en pulses with din 41,42,43, then state IDLE.
- Round-robin fairness: both requesters continuously valid, 2-byte packets -> grant order 0,1,0,1. Output bytes alternate by packet, one dead cycle between packets.
- Burst limit: MAX_BURST=4, req1 streams 10 bytes with no last -> writes occur in groups of 4, 4, 2. Other requesters are serviced between the groups when valid.
- Backpressure: fifo_full=1 for 5 cycles mid-packet -> no fifo_wr_en and req_ready[g]=0 during those cycles. Transfer resumes the cycle full drops; no byte is lost or duplicated.
- Reset mid-grant: rst asserted during byte 2 of a 4-byte packet -> next cycle IDLE, rr_ptr=0, busy=0. After reset, requester 0 is granted first.
